serial_adder: RTL
=================

# serial_adder

Parametrised bit-serial adder/subtractor built around a single full-adder cell, formed from two cascaded half-adder stages plus an OR. It accepts a WIDTH-bit operand pair on a start pulse. It processes one bit per clock, LSB first, and reports sum, carry-out and signed overflow with a one-cycle done pulse. It is the area-minimal arithmetic unit for control paths where latency is not critical.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = A+B+cin, 1 = A−B (cin ignored, carry seeded with 1, B inverted)
- cin  in  1  carry-in for add mode
- a  in  WIDTH  operand A, latched on accepted start
- b  in  WIDTH  operand B, latched on accepted start
- busy  out  1  high while bits are being processed
- done  out  1  single-cycle completion pulse
- sum  out  WIDTH  result; held stable until the next completion
- cout  out  1  carry-out; in sub mode 1 = no borrow
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, latch a, b^{WIDTH{sub}}, carry ← sub ? 1 : cin, bit counter ← 0, go to RUN. If start=0, stay in IDLE.
- RUN: each cycle adds the LSBs of the operand shift registers plus the carry. Shift the sum bit into the result shift register MSB-first and shift the operands right. Update the carry and increment the counter. On the bit with counter = WIDTH−1, record the carry-in to that bit for ovf, commit the result register to sum, cout and ovf, and go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE unconditionally.
- start is ignored in RUN and DONE. Operands changing after acceptance have no effect.
- sum, cout and ovf change only at the commit edge. Intermediate bits are never visible.
- Counter width: $clog2(WIDTH). No wrap; the RUN exit occurs at WIDTH−1.
- Reset, from any state including mid-RUN: state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal registers cleared. A partial result is discarded and no done pulse is produced.

## Timing
- start sampled high at edge k (state IDLE) → busy=1 from after edge k through edge k+WIDTH.
- Commit at edge k+WIDTH → done=1 and sum/cout/ovf valid in the cycle after edge k+WIDTH.
- Edge k+WIDTH+1 → IDLE. The next start is accepted no earlier than edge k+WIDTH+2.
- Throughput: one operation per WIDTH+2 cycles with start held high.
- Outputs are registered. There is no combinational path from inputs to outputs.
- busy and done are never high simultaneously.

## Structure
- Shared package adder_pkg: state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2). Package is shared with future multi-bit serial arithmetic blocks.
- One sub-module: full_adder_cell. It is combinational and built from two half-adder stages: s = a^b^ci, co = (a&b)|((a^b)&ci). It is instantiated once.
- Top level holds the FSM, counter, operand/result shift registers, carry flop and output registers.

## Test plan
- Reset: assert rst for 2 cycles mid-idle → busy=0, done=0, sum=8'h00, cout=0, ovf=0.
- Add, WIDTH=8: a=8'h3C, b=8'h0F, cin=0, start at edge k → done only after edge k+8, sum=8'h4B, cout=0, ovf=0. Also a=8'hFF, b=8'h01 → sum=8'h00, cout=1, ovf=0.
- Signed overflow: a=8'h7F, b=8'h01, cin=1 → sum=8'h81, cout=0, ovf=1.
- Subtract: sub=1, a=8'h05, b=8'h07 → sum=8'hFE, cout=0 (borrow), ovf=0. Also a=8'h80, b=8'h01 → sum=8'h7F, cout=1, ovf=1.
- Ignore and abort: change a/b and pulse start during RUN → result reflects the original operands. Separately, assert rst at the 4th RUN cycle → busy=0 after that edge, sum=0, no done pulse.
- Back-to-back: start held high with a sequence of operand pairs → acceptances spaced exactly 10 cycles apart, each with a correct single-cycle done.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the serial arithmetic blocks.
// The state encoding is reused by future multi-bit serial units.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder assembled from two cascaded half-adder stages
// whose carries are merged with an OR.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic hs1;
  logic hc1;
  logic hc2;

  // First half adder combines the operand bits, the second folds in the carry.
  always_comb begin
    hs1 = a ^ b;
    hc1 = a & b;
    s   = hs1 ^ ci;
    hc2 = hs1 & ci;
    co  = hc1 | hc2;
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, one bit per clock, LSB first,
// with carry-out, signed overflow and a single-cycle done pulse.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             fa_s;
  logic             fa_co;

  full_adder_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1: B is inverted on entry and the carry seeded with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b ^ {WIDTH{sub}};
            carry  <= sub ? 1'b1 : cin;
            cnt    <= '0;
            res_sr <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {fa_s, res_sr[WIDTH-1:1]};
          carry  <= fa_co;
          cnt    <= cnt + 1'b1;
          // The carry into the MSB is still in the carry flop on the final bit.
          if (last_bit) begin
            sum_q  <= {fa_s, res_sr[WIDTH-1:1]};
            cout_q <= fa_co;
            ovf_q  <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
